instr_prefetch_buffer: RTL and testbench
========================================

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries and max outstanding requests (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  redirect request from execute (branch taken).
REQ-006 flush_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word-aligned read address, valid with imem_req.
REQ-009 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid; responses return in request order, >=1 cycle after grant.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 out_valid  output  1  instruction available to fetch/IF-ID.
REQ-013 out_instr  output  32  head instruction.
REQ-014 out_pc  output  32  address of head instruction.
REQ-015 out_ready  input  1  consumer accepts head when out_valid=1.

Function
REQ-016 Storage SHALL be a DEPTH-entry in-order FIFO of {pc, instr}; out_instr/out_pc SHALL come from the head entry (registered storage, no memory-to-output bypass).
REQ-017 Fetch pointer fpc SHALL drive imem_addr and advance by 4 (mod 2^32 wrap) on each cycle with imem_req && imem_gnt.
REQ-018 imem_req SHALL be 1 iff reset deasserted, flush=0, and (fifo_count + live_outstanding) < DEPTH.
REQ-019 Each granted request SHALL record its pc in an in-order tag queue; on imem_rvalid the oldest tag pairs with imem_rdata.
REQ-020 live_outstanding and discard_count SHALL be counters of width clog2(DEPTH)+1; their sum SHALL never exceed DEPTH.
REQ-021 A non-discarded response SHALL be written to the FIFO tail at that edge; out_valid SHALL rise the following cycle (grant at N, rvalid at N+1 -> out_valid at N+2).
REQ-022 Pop SHALL occur on out_valid && out_ready; simultaneous push and pop SHALL keep fifo_count unchanged.
REQ-023 With 1-cycle memory latency and out_ready held 1, sustained throughput SHALL be one instruction per cycle.
REQ-024 out_valid SHALL equal (fifo_count != 0) && !flush; a handshake in a flush cycle SHALL be ignored.
REQ-025 On flush at edge: fifo_count:=0, fpc:=flush_pc, discard_count:=discard_count+live_outstanding, live_outstanding:=0; tag queue cleared.
REQ-026 While discard_count>0, each imem_rvalid SHALL decrement discard_count and drop the data; a response coincident with flush SHALL be dropped.
REQ-027 New requests MAY issue during discard; the credit rule of REQ-018 SHALL count discard_count as outstanding.
REQ-028 Back-to-back flushes SHALL each apply, the last fpc winning; no discarded instruction SHALL ever reach out_valid.
REQ-029 FIFO full SHALL be impossible to overflow by construction (REQ-018); an rvalid with no outstanding request SHALL be ignored (assertion in bench).

Reset
REQ-030 On reset=0, asynchronously: fpc:=RESET_PC, fifo_count, live_outstanding, discard_count, pointers :=0; out_valid=0, imem_req=0.
REQ-031 First imem_req SHALL assert in the first cycle with reset=1, address RESET_PC.
REQ-032 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving after release with no outstanding count SHALL be ignored.

Structure
REQ-033 Bus widths SHALL use `INSTR_BUS and `INSTR_ADDR_BUS from defines.sv; the fetch-entry typedef {pc, instr} SHALL live in a shared package riscv_pkg.
REQ-034 FIFO storage and pointers SHALL be a sub-module prefetch_fifo (parameter DEPTH, push/pop/count interface).

Verification
REQ-035 Reset release, gnt=1, 1-cycle latency, out_ready=1 -> out_pc 0x0,0x4,0x8... one per cycle starting cycle 2.
REQ-036 out_ready=0 for 10 cycles -> exactly 4 entries held, imem_req=0 once count+outstanding=4, no data lost on resume.
REQ-037 flush with flush_pc=0x100 while 2 requests outstanding -> both responses dropped, next out_pc=0x100.
REQ-038 flush_pc=0x203 -> imem_addr=0x200; fpc at 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-039 Random gnt stalls, 1-3 cycle latency, random out_ready/flush -> scoreboard: out_pc sequence matches reference model, no duplicates.
REQ-040 reset pulsed with 3 in flight -> out_valid=0, next out_pc=RESET_PC, stale rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: the {pc, instr} entry carried from fetch to decode.
`ifndef INSTR_BUS
`include "defines.sv"
`endif

package riscv_pkg;

  typedef struct packed {
    logic [`INSTR_ADDR_BUS] pc;
    logic [`INSTR_BUS]      instr;
  } fetch_entry_t;

  function automatic logic [`INSTR_ADDR_BUS] word_align(input logic [`INSTR_ADDR_BUS] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/defines.sv
`ifndef INSTR_BUS
`define INSTR_BUS 31:0
`define INSTR_ADDR_BUS 31:0
`endif

// File: rtl/prefetch_fifo.sv
// In-order DEPTH-entry FIFO of fetch entries; head is read straight from registered storage.
// Push visible at head the cycle after the write; caller must never push when full or pop when empty.
`ifndef INSTR_BUS
`include "defines.sv"
`endif

module prefetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  fetch_entry_t         push_dat,
  input  logic                 pop,
  output fetch_entry_t         head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetcher: issues sequential word fetches under a DEPTH credit limit and queues responses.
// Grant at N, rvalid at N+1 -> out_valid at N+2; out_ready low fills the FIFO and then stops imem_req.
`ifndef INSTR_BUS
`include "defines.sv"
`endif

module instr_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int                     DEPTH    = 4,
  parameter logic [`INSTR_ADDR_BUS] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [`INSTR_ADDR_BUS] flush_pc,
  output logic                   imem_req,
  output logic [`INSTR_ADDR_BUS] imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [`INSTR_BUS]      imem_rdata,
  output logic                   out_valid,
  output logic [`INSTR_BUS]      out_instr,
  output logic [`INSTR_ADDR_BUS] out_pc,
  input  logic                   out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [`INSTR_ADDR_BUS] fpc;
  logic [CW-1:0]          live_cnt;
  logic [CW-1:0]          discard_cnt;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            credit_used;
  logic [`INSTR_ADDR_BUS] tag_q [DEPTH];
  logic [AW-1:0]          tag_wr;
  logic [AW-1:0]          tag_rd;
  logic                   grant;
  logic                   rsp_live;
  logic                   rsp_drop;
  logic                   push;
  logic                   pop;
  fetch_entry_t           push_dat;
  fetch_entry_t           head;

  // Requests still owed by memory but already abandoned keep holding a credit.
  assign credit_used = {1'b0, fifo_count} + {1'b0, live_cnt} + {1'b0, discard_cnt};
  assign imem_req    = reset && !flush && (credit_used < DEPTH_W);
  assign imem_addr   = fpc;
  assign grant       = imem_req && imem_gnt;

  assign rsp_drop = imem_rvalid && (discard_cnt != '0);
  assign rsp_live = imem_rvalid && (discard_cnt == '0) && (live_cnt != '0);
  assign push     = rsp_live && !flush;
  assign push_dat = '{pc: tag_q[tag_rd], instr: imem_rdata};

  assign out_valid = (fifo_count != '0) && !flush;
  assign pop       = out_valid && out_ready;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC;
      live_cnt    <= '0;
      discard_cnt <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else if (flush) begin
      // Everything still live becomes discard, minus a response consumed this very edge.
      fpc         <= word_align(flush_pc);
      live_cnt    <= '0;
      discard_cnt <= discard_cnt - CW'(rsp_drop) + live_cnt - CW'(rsp_live);
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (grant) begin
        fpc    <= fpc + 32'd4;
        tag_wr <= tag_wr + 1'b1;
      end
      if (rsp_live) tag_rd <= tag_rd + 1'b1;
      live_cnt    <= live_cnt + CW'(grant) - CW'(rsp_live);
      discard_cnt <= discard_cnt - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_q[tag_wr] <= fpc;
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer: in-order memory model with variable latency.
`timescale 1ns/1ps
module tb_instr_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fpc;
  int          cyc;
  int          last_rdy;
  int          tests;
  int          fails;
  int          lat_min;
  int          lat_max;
  int          gnt_mode;
  int          rdy_mode;
  bit          inject_stale;
  logic        last_ov;
  logic        last_req;
  logic        last_pop;
  logic [31:0] last_pop_pc;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update the model for the coming posedge.
  task automatic step(input logic fl, input logic [31:0] fl_pc);
    int lat;
    int rdy;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_q.size() != 0 && mem_q[0].rdy <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
      mem_q.delete(0);
    end else if (inject_stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b0;
      1:       imem_gnt = 1'b1;
      default: imem_gnt = ($urandom_range(0, 3) != 0);
    endcase
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    flush    = fl;
    flush_pc = fl_pc;
    #1;
    last_ov   = out_valid;
    last_req  = imem_req;
    last_addr = imem_addr;
    last_pop  = 1'b0;
    if (fl) begin
      check_eq("flush_req", 32'(imem_req), 32'd0);
      check_eq("flush_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      exp_fpc = fl_pc & ~32'h3;
    end else begin
      if (imem_req && imem_gnt) begin
        check_eq("imem_addr", imem_addr, exp_fpc);
        lat = $urandom_range(lat_max, lat_min);
        rdy = cyc + lat;
        if (rdy <= last_rdy) rdy = last_rdy + 1;
        last_rdy = rdy;
        mem_q.push_back('{addr: imem_addr, rdy: rdy});
        exp_q.push_back(exp_fpc);
        exp_fpc += 32'd4;
      end
      if (out_valid && out_ready) begin
        last_pop    = 1'b1;
        last_pop_pc = out_pc;
        if (exp_q.size() == 0) begin
          check_eq("pop_with_nothing_expected", 32'(out_valid), 32'd0);
        end else begin
          check_eq("out_pc", out_pc, exp_q[0]);
          check_eq("out_instr", out_instr, mem_word(exp_q[0]));
          exp_q.delete(0);
        end
      end
    end
    cyc++;
  endtask

  task automatic run_first_pop(input int n, input logic [31:0] want, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0);
      if (last_pop && !seen) begin
        seen = 1'b1;
        check_eq(tag, last_pop_pc, want);
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  pops;
    bit  wrapped;
    tests = 0; fails = 0; cyc = 0; last_rdy = 0;
    lat_min = 1; lat_max = 1; gnt_mode = 1; rdy_mode = 1; inject_stale = 1'b0;
    reset = 1'b0; flush = 1'b0; flush_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    exp_fpc = RESET_PC;

    #12;
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_imem_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, RESET_PC);

    // Streaming: one instruction per cycle from the third cycle on.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0);
      check_eq("stream_out_valid", 32'(last_ov), 32'(i >= 2));
      if (i >= 2) check_eq("stream_pc", last_pop_pc, RESET_PC + 32'(4 * (i - 2)));
    end

    // Consumer stall fills the buffer and throttles requests.
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    check_eq("stall_req", 32'(last_req), 32'd0);
    check_eq("stall_out_valid", 32'(last_ov), 32'd1);
    gnt_mode = 0; rdy_mode = 1; pops = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0);
      if (last_pop) pops++;
    end
    check_eq("stall_held_entries", 32'(pops), 32'(DEPTH));

    // Flush with two requests outstanding.
    gnt_mode = 1; rdy_mode = 0; lat_min = 3; lat_max = 3;
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, 32'h0000_0100);
    lat_min = 1; lat_max = 1; rdy_mode = 1;
    run_first_pop(10, 32'h0000_0100, "flush_first_pc");

    // Misaligned redirect target and back-to-back flushes.
    step(1'b1, 32'h0000_0203);
    step(1'b0, '0);
    check_eq("align_addr", last_addr, 32'h0000_0200);
    run_first_pop(6, 32'h0000_0200, "align_first_pc");
    step(1'b1, 32'h0000_0400);
    step(1'b1, 32'h0000_0504);
    run_first_pop(6, 32'h0000_0504, "double_flush_pc");

    // Fetch pointer wraps past the top of the address space.
    step(1'b1, 32'hFFFF_FFF4);
    wrapped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0);
      if (last_pop && last_pop_pc == 32'h0) wrapped = 1'b1;
    end
    check_eq("wrap_seen", 32'(wrapped), 32'd1);

    // Random stalls, latency, backpressure and redirects.
    gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) step(1'b1, $urandom);
      else step(1'b0, '0);
    end

    // Reset with three requests in flight, then a stale response.
    gnt_mode = 0; rdy_mode = 1;
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    gnt_mode = 1; rdy_mode = 0; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("midreset_out_valid", 32'(out_valid), 32'd0);
    check_eq("midreset_imem_req", 32'(imem_req), 32'd0);
    mem_q.delete();
    exp_q.delete();
    exp_fpc  = RESET_PC;
    last_rdy = cyc;
    @(negedge clk);
    reset = 1'b1;
    gnt_mode = 0; rdy_mode = 1; inject_stale = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0);
      check_eq("stale_out_valid", 32'(last_ov), 32'd0);
    end
    inject_stale = 1'b0;
    step(1'b0, '0);
    check_eq("stale_ignored_out_valid", 32'(last_ov), 32'd0);
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    run_first_pop(10, RESET_PC, "reset_first_pc");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
